// File: rtl/core_ibex_trace_pkg.sv
// Shared constants for the ID-stage instruction trace FIFO: flag bit positions
// and the occupancy-counter width helper.
package core_ibex_trace_pkg;

  localparam int FLAG_JUMP       = 0;
  localparam int FLAG_BRANCH     = 1;
  localparam int FLAG_COMPRESSED = 2;
  localparam int FLAG_ERR        = 3;
  localparam int FLAG_ORDER_ERR  = 4;
  localparam int NUM_FLAGS       = 5;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/core_ibex_trace_fifo_mem.sv
// Generic DEPTH x W register-array FIFO, first-word-fall-through read port.
// A pop is ignored while empty; a push at full is accepted only with a pop.
module core_ibex_trace_fifo_mem
  import core_ibex_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/core_ibex_instr_trace_fifo.sv
// ID-stage instruction capture buffer with stall counting, drop accounting and
// optional RVFI order continuity check (enabled by CORE_IBEX_TRACE_ORDER_CHECK_EN).
module core_ibex_instr_trace_fifo
  import core_ibex_trace_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int STALL_CNT_W = 8,
  parameter int DROP_CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_id_i,
  input  logic                         rvfi_id_done_i,
  input  logic                         err_id_i,
  input  logic                         is_compressed_id_i,
  input  logic                         branch_taken_id_i,
  input  logic                         jump_set_id_i,
  input  logic                         stall_id_i,
  input  logic [15:0]                  instr_compressed_id_i,
  input  logic [DATA_WIDTH-1:0]        instr_id_i,
  input  logic [DATA_WIDTH-1:0]        pc_id_i,
  input  logic [DATA_WIDTH-1:0]        branch_target_id_i,
  input  logic [63:0]                  rvfi_order_id_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_WIDTH-1:0]        out_pc_o,
  output logic [DATA_WIDTH-1:0]        out_instr_o,
  output logic [DATA_WIDTH-1:0]        out_target_o,
  output logic [63:0]                  out_order_o,
  output logic [NUM_FLAGS-1:0]         out_flags_o,
  output logic [STALL_CNT_W-1:0]       out_stall_cnt_o,
  output logic [cnt_width(DEPTH)-1:0]  count_o,
  output logic                         overflow_o,
  output logic [DROP_CNT_W-1:0]        drop_cnt_o,
  output logic                         order_err_o
);

  typedef struct packed {
    logic [63:0]            order;
    logic [DATA_WIDTH-1:0]  target;
    logic [DATA_WIDTH-1:0]  instr;
    logic [DATA_WIDTH-1:0]  pc;
    logic [NUM_FLAGS-1:0]   flags;
    logic [STALL_CNT_W-1:0] stall;
  } entry_t;

  localparam int W = $bits(entry_t);

  entry_t                 wr_entry, rd_entry, head;
  logic [W-1:0]           rd_word;
  logic                   capture, pop, full, empty, drop, order_mis;
  logic [STALL_CNT_W-1:0] stall_cnt;

  assign capture = valid_id_i && rvfi_id_done_i;
  assign pop     = out_valid_o && out_ready_i;
  assign drop    = capture && full && !pop;

`ifdef CORE_IBEX_TRACE_ORDER_CHECK_EN
  logic [63:0] last_order;
  logic        baseline_vld;

  // First capture after reset only seeds the baseline; dropped captures still advance it.
  assign order_mis = capture && baseline_vld && (rvfi_order_id_i != last_order + 64'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_order   <= '0;
      baseline_vld <= 1'b0;
      order_err_o  <= 1'b0;
    end else if (capture) begin
      last_order   <= rvfi_order_id_i;
      baseline_vld <= 1'b1;
      if (order_mis) order_err_o <= 1'b1;
    end
  end
`else
  assign order_mis   = 1'b0;
  assign order_err_o = 1'b0;
`endif

  always_comb begin
    wr_entry        = '0;
    wr_entry.order  = rvfi_order_id_i;
    wr_entry.target = branch_target_id_i;
    wr_entry.instr  = is_compressed_id_i ? DATA_WIDTH'(instr_compressed_id_i) : instr_id_i;
    wr_entry.pc     = pc_id_i;
    wr_entry.stall  = stall_cnt;
    wr_entry.flags[FLAG_JUMP]       = jump_set_id_i;
    wr_entry.flags[FLAG_BRANCH]     = branch_taken_id_i;
    wr_entry.flags[FLAG_COMPRESSED] = is_compressed_id_i;
    wr_entry.flags[FLAG_ERR]        = err_id_i;
    wr_entry.flags[FLAG_ORDER_ERR]  = order_mis;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (capture) stall_cnt <= '0;
      else if (valid_id_i && stall_id_i && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
      end
    end
  end

  core_ibex_trace_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_word),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  // Stale array contents must not leak onto the data outputs while empty.
  assign rd_entry        = entry_t'(rd_word);
  assign head            = empty ? '0 : rd_entry;
  assign out_valid_o     = !empty;
  assign out_pc_o        = head.pc;
  assign out_instr_o     = head.instr;
  assign out_target_o    = head.target;
  assign out_order_o     = head.order;
  assign out_flags_o     = head.flags;
  assign out_stall_cnt_o = head.stall;

endmodule

// File: tb/tb_core_ibex_instr_trace_fifo.sv
// Randomized bench for core_ibex_instr_trace_fifo with a queue-based reference model.
module tb_core_ibex_instr_trace_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int SW    = 8;
  localparam int DCW   = 16;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [SW-1:0]  SMAX = '1;
  localparam logic [DCW-1:0] DMAX = '1;

  logic           clk = 1'b0, reset = 1'b1;
  logic           valid_id, done_id, err_id, cmp_id, br_id, jmp_id, stall_id, out_ready;
  logic [15:0]    cinstr;
  logic [DW-1:0]  instr, pc, target;
  logic [63:0]    order;
  logic           out_valid, overflow, order_err;
  logic [DW-1:0]  out_pc, out_instr, out_target;
  logic [63:0]    out_order;
  logic [4:0]     out_flags;
  logic [SW-1:0]  out_stall;
  logic [CW-1:0]  count;
  logic [DCW-1:0] drop_cnt;

  always #5 clk = ~clk;

  core_ibex_instr_trace_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STALL_CNT_W(SW), .DROP_CNT_W(DCW)) dut (
    .clk(clk), .reset(reset), .valid_id_i(valid_id), .rvfi_id_done_i(done_id),
    .err_id_i(err_id), .is_compressed_id_i(cmp_id), .branch_taken_id_i(br_id),
    .jump_set_id_i(jmp_id), .stall_id_i(stall_id), .instr_compressed_id_i(cinstr),
    .instr_id_i(instr), .pc_id_i(pc), .branch_target_id_i(target), .rvfi_order_id_i(order),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc), .out_instr_o(out_instr),
    .out_target_o(out_target), .out_order_o(out_order), .out_flags_o(out_flags),
    .out_stall_cnt_o(out_stall), .count_o(count), .overflow_o(overflow),
    .drop_cnt_o(drop_cnt), .order_err_o(order_err)
  );

  typedef struct {
    logic [DW-1:0] pc, instr, target;
    logic [63:0]   order;
    logic [4:0]    flags;
    logic [SW-1:0] stall;
  } entry_t;

  entry_t         mq[$];
  logic [63:0]    m_last;
  bit             m_base, m_ovf, m_oerr;
  logic [SW-1:0]  m_stall;
  logic [DCW-1:0] m_drop;
  int vectors = 0, miscompares = 0;

`ifdef CORE_IBEX_TRACE_ORDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Advance the reference model by one clock with the currently driven inputs, then step.
  task automatic tick();
    entry_t e;
    bit pop;
    pop = (mq.size() > 0) && out_ready;
    if (reset) begin
      mq.delete(); m_base = 0; m_ovf = 0; m_oerr = 0; m_stall = '0; m_drop = '0; m_last = '0;
    end else begin
      if (valid_id && done_id) begin
        e.pc = pc; e.target = target; e.order = order; e.stall = m_stall;
        e.instr = cmp_id ? {16'h0, cinstr} : instr;
        e.flags = {1'b0, err_id, cmp_id, br_id, jmp_id};
        if (CHK) begin
          if (m_base && order != m_last + 64'd1) begin e.flags[4] = 1'b1; m_oerr = 1; end
          m_last = order; m_base = 1;
        end
        m_stall = '0;
        if (pop) begin void'(mq.pop_front()); pop = 0; end
        if (mq.size() < DEPTH) mq.push_back(e);
        else begin m_ovf = 1; if (m_drop != DMAX) m_drop++; end
      end else if (valid_id && stall_id && m_stall != SMAX) m_stall++;
      if (pop) void'(mq.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    valid_id = 0; done_id = 0; stall_id = 0;
  endtask

  task automatic drive_cap(input logic [63:0] ord);
    valid_id = 1; done_id = 1; stall_id = 0;
    err_id = 1'($urandom); cmp_id = 1'($urandom); br_id = 1'($urandom); jmp_id = 1'($urandom);
    cinstr = 16'($urandom); instr = $urandom; pc = $urandom; target = $urandom; order = ord;
  endtask

  task automatic do_reset();
    reset = 1; drive_idle(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (overflow !== 1'b0 || drop_cnt !== '0 || order_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_status got ovf=%0b drop=%0d oerr=%0b want 0/0/0", overflow, drop_cnt, order_err); end
    vectors++; if (out_pc !== '0 || out_order !== '0 || out_flags !== '0) begin
      miscompares++; $display("FAIL reset_data got pc=%0h order=%0d flags=%0b want 0", out_pc, out_order, out_flags); end
  endtask

  task automatic test_basic();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      drive_cap(64'd10 + 64'(i)); tick();
      vectors++; if (out_valid !== 1'b1 || out_order !== 64'd10 + 64'(i) || out_stall !== '0) begin
        miscompares++; $display("FAIL basic_out%0d got v=%0b order=%0d stall=%0d want 1/%0d/0", i, out_valid, out_order, out_stall, 10 + i); end
      vectors++; if (out_pc !== mq[0].pc || out_instr !== mq[0].instr || out_flags !== mq[0].flags) begin
        miscompares++; $display("FAIL basic_fields%0d got pc=%0h instr=%0h flags=%0b want %0h/%0h/%0b", i, out_pc, out_instr, out_flags, mq[0].pc, mq[0].instr, mq[0].flags); end
    end
    drive_idle(); tick();
    vectors++; if (count !== '0 || out_valid !== 1'b0 || order_err !== 1'b0) begin
      miscompares++; $display("FAIL basic_drain got count=%0d v=%0b oerr=%0b want 0/0/0", count, out_valid, order_err); end
  endtask

  task automatic test_stall();
    out_ready = 1;
    valid_id = 1; done_id = 0; stall_id = 1;
    for (int i = 0; i < 5; i++) tick();
    drive_cap(64'd13); tick();
    vectors++; if (out_stall !== 8'd5) begin miscompares++; $display("FAIL stall5 got %0d want 5", out_stall); end
    valid_id = 1; done_id = 0; stall_id = 1;
    for (int i = 0; i < 300; i++) tick();
    drive_cap(64'd14); tick();
    vectors++; if (out_stall !== SMAX) begin miscompares++; $display("FAIL stall_sat got %0d want %0d", out_stall, SMAX); end
    drive_idle(); tick();
  endtask

  task automatic test_overflow();
    do_reset(); out_ready = 0;
    for (int i = 0; i < 10; i++) begin drive_cap(64'd100 + 64'(i)); tick(); end
    drive_idle();
    vectors++; if (count !== CW'(8) || overflow !== 1'b1 || drop_cnt !== DCW'(2)) begin
      miscompares++; $display("FAIL overflow got count=%0d ovf=%0b drop=%0d want 8/1/2", count, overflow, drop_cnt); end
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      vectors++; if (out_valid !== 1'b1 || out_order !== 64'd100 + 64'(i)) begin
        miscompares++; $display("FAIL overflow_drain%0d got v=%0b order=%0d want 1/%0d", i, out_valid, out_order, 100 + i); end
      tick();
    end
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL overflow_empty got %0d want 0", count); end
  endtask

  task automatic test_full_push_pop();
    do_reset(); out_ready = 0;
    for (int i = 0; i < 8; i++) begin drive_cap(64'd200 + 64'(i)); tick(); end
    out_ready = 1; drive_cap(64'd208); tick(); drive_idle();
    vectors++; if (count !== CW'(8) || drop_cnt !== '0 || overflow !== 1'b0 || out_order !== 64'd201) begin
      miscompares++; $display("FAIL full_pushpop got count=%0d drop=%0d ovf=%0b head=%0d want 8/0/0/201", count, drop_cnt, overflow, out_order); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (out_order !== 64'd201 + 64'(i)) begin
        miscompares++; $display("FAIL full_drain%0d got %0d want %0d", i, out_order, 201 + i); end
      tick();
    end
  endtask

  task automatic test_order_err();
    logic [63:0] ords [3];
    ords[0] = 64'd5; ords[1] = 64'd6; ords[2] = 64'd8;
    do_reset(); out_ready = 0;
    for (int i = 0; i < 3; i++) begin drive_cap(ords[i]); tick(); end
    drive_idle();
    vectors++; if (order_err !== CHK) begin miscompares++; $display("FAIL order_sticky got %0b want %0b", order_err, CHK); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (out_flags[4] !== (CHK && i == 2)) begin
        miscompares++; $display("FAIL order_flag%0d got %0b want %0b", i, out_flags[4], CHK && i == 2); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); out_ready = 0;
    for (int i = 0; i < 4; i++) begin drive_cap(64'd300 + 64'(i)); tick(); end
    reset = 1; drive_cap(64'd500); tick(); reset = 0;
    vectors++; if (count !== '0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL midreset got count=%0d v=%0b want 0/0", count, out_valid); end
    drive_cap(64'd900); tick(); drive_idle();
    vectors++; if (count !== CW'(1) || order_err !== 1'b0 || out_flags[4] !== 1'b0 || out_order !== 64'd900) begin
      miscompares++; $display("FAIL midreset_base got count=%0d oerr=%0b f4=%0b order=%0d want 1/0/0/900", count, order_err, out_flags[4], out_order); end
  endtask

  task automatic test_random();
    logic [63:0] nxt;
    entry_t h;
    do_reset(); nxt = 64'($urandom);
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0) ? (i % 200 > 40) : 1'b0;
      if ($urandom_range(0, 9) < 7 && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 15) == 0) nxt = nxt + 64'($urandom_range(2, 5));
        drive_cap(nxt); nxt = nxt + 64'd1;
      end else begin
        valid_id = 1'($urandom); done_id = 0; stall_id = 1'($urandom);
      end
      tick();
      h = '{default: '0};
      if (mq.size() > 0) h = mq[0];
      vectors++;
      if (out_valid !== (mq.size() > 0) || count !== CW'(mq.size()) || overflow !== m_ovf ||
          drop_cnt !== m_drop || order_err !== m_oerr || out_pc !== h.pc || out_instr !== h.instr ||
          out_target !== h.target || out_order !== h.order || out_flags !== h.flags || out_stall !== h.stall) begin
        miscompares++;
        $display("FAIL random%0d got v=%0b cnt=%0d ovf=%0b drop=%0d oerr=%0b order=%0h flags=%0b stall=%0d instr=%0h want v=%0b cnt=%0d ovf=%0b drop=%0d oerr=%0b order=%0h flags=%0b stall=%0d instr=%0h",
                 i, out_valid, count, overflow, drop_cnt, order_err, out_order, out_flags, out_stall, out_instr,
                 mq.size() > 0, mq.size(), m_ovf, m_drop, m_oerr, h.order, h.flags, h.stall, h.instr);
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle(); out_ready = 0; err_id = 0; cmp_id = 0; br_id = 0; jmp_id = 0;
    cinstr = '0; instr = '0; pc = '0; target = '0; order = '0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_full_push_pop();
    test_order_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
